// File: rtl/trg_frame_tx.sv
// trg_frame_tx: threshold-triggered AXI4-Stream frame transmitter with output FIFO.
// Define TRG_TX_HEADER_EN to prepend a header word (seq/timestamp/baseline) to each frame.
module trg_frame_tx #(
    parameter int         THRESHOLD            = 10,
    parameter int         ADC_RESOLUTION_WIDTH = 12,
    parameter int         S_AXIS_TDATA_WIDTH   = 128,
    parameter int         FRAME_LEN            = 16,
    parameter int         FIFO_DEPTH           = 64,
    parameter logic [7:0] CH_ID                = 8'd0
) (
    input  logic                          AXIS_ACLK,
    input  logic                          AXIS_ARESETN,
    input  logic [1:0]                    EXEC_STATE,
    input  logic [11:0]                   I_BASELINE,
    input  logic                          I_BL_VALID,
    input  logic [S_AXIS_TDATA_WIDTH-1:0] S_AXIS_TDATA,
    input  logic                          S_AXIS_TVALID,
    output logic [S_AXIS_TDATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic                          M_AXIS_TVALID,
    input  logic                          M_AXIS_TREADY,
    output logic                          M_AXIS_TLAST,
    output logic [15:0]                   O_DROP_CNT,
    output logic                          O_BUSY
);

    localparam int DW = S_AXIS_TDATA_WIDTH;
    localparam int NL = DW / 16;
    localparam int AW = ADC_RESOLUTION_WIDTH;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
`ifdef TRG_TX_HEADER_EN
    localparam int NEED = FRAME_LEN + 1;
`else
    localparam int NEED = FRAME_LEN;
`endif
    localparam logic signed [13:0] THR_OFS = 14'((THRESHOLD * (1 << AW)) / 100);

    typedef enum logic {
        W_IDLE,
        W_DATA
    } wstate_t;

    wstate_t            state_q, state_d;
    logic [CW-1:0]      wcnt_q, wcnt_d;
    logic [11:0]        bl_q, bl_d;
    logic [15:0]        drop_q, drop_d;
    logic [DW-1:0]      stg_data_q;
    logic               stg_vld_q;
    logic [DW:0]        mem [FIFO_DEPTH];
    logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [PW:0]        cnt_q;
    logic               wr_en, rd_en, space_ok, hit, last_w;
    logic [DW:0]        wr_data;
    logic [DW-1:0]      data_word;
    logic signed [13:0] thr;
    logic signed [12:0] s13, b13, d13;
    logic               unused_ok;

`ifdef TRG_TX_HEADER_EN
    logic [47:0]   ts_q;
    logic [15:0]   seq_q, seq_d;
    logic [DW-1:0] hdr_word;

    // Header word assembled from live baseline, timestamp and sequence number.
    always_comb begin
        hdr_word            = '0;
        hdr_word[127:120]   = 8'hAA;
        hdr_word[119:112]   = CH_ID;
        hdr_word[111:64]    = ts_q;
        hdr_word[63:52]     = I_BASELINE;
        hdr_word[31:16]     = seq_q;
        hdr_word[15:0]      = 16'(FRAME_LEN);
    end

    // Free-running timestamp and frame sequence counter.
    always_ff @(posedge AXIS_ACLK) begin
        if (!AXIS_ARESETN) begin
            ts_q  <= '0;
            seq_q <= '0;
        end else begin
            ts_q  <= ts_q + 48'd1;
            seq_q <= seq_d;
        end
    end

    assign unused_ok = ^stg_data_q;
`else
    assign unused_ok = ^{stg_data_q, CH_ID};
`endif

    // Trigger detect on the live input word against baseline plus offset.
    always_comb begin
        thr = 14'($signed(I_BASELINE)) + THR_OFS;
        hit = 1'b0;
        for (int i = 0; i < NL; i++) begin
            if (14'($signed(S_AXIS_TDATA[16*i +: AW])) > thr) hit = 1'b1;
        end
        hit = hit & S_AXIS_TVALID & I_BL_VALID & (EXEC_STATE == 2'b11);
    end

    // Baseline-subtracted, sign-extended lanes of the staged word.
    always_comb begin
        data_word = '0;
        b13       = 13'($signed(bl_q));
        s13       = '0;
        d13       = '0;
        for (int i = 0; i < NL; i++) begin
            s13 = 13'($signed(stg_data_q[16*i +: AW]));
            d13 = s13 - b13;
            data_word[16*i +: 16] = 16'(d13);
        end
    end

    assign space_ok = (int'(cnt_q) <= FIFO_DEPTH - NEED);
    assign rd_en    = M_AXIS_TVALID & M_AXIS_TREADY;

    // Write FSM: reserve space on trigger, then push FRAME_LEN staged words.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        bl_d    = bl_q;
        drop_d  = drop_q;
        wr_en   = 1'b0;
        wr_data = '0;
        last_w  = 1'b0;
`ifdef TRG_TX_HEADER_EN
        seq_d   = seq_q;
`endif
        unique case (state_q)
            W_IDLE: begin
                if (hit) begin
`ifdef TRG_TX_HEADER_EN
                    seq_d = seq_q + 16'd1;
`endif
                    if (space_ok) begin
                        bl_d    = I_BASELINE;
                        wcnt_d  = '0;
                        state_d = W_DATA;
`ifdef TRG_TX_HEADER_EN
                        wr_en   = 1'b1;
                        wr_data = {1'b0, hdr_word};
`endif
                    end else if (drop_q != 16'hFFFF) begin
                        drop_d = drop_q + 16'd1;
                    end
                end
            end
            W_DATA: begin
                if (stg_vld_q) begin
                    last_w  = (wcnt_q == CW'(FRAME_LEN - 1));
                    wr_en   = 1'b1;
                    wr_data = {last_w, data_word};
                    wcnt_d  = wcnt_q + 1'b1;
                    if (last_w) state_d = W_IDLE;
                end
            end
            default: state_d = W_IDLE;
        endcase
    end

    // FSM state, counters, input stage and FIFO pointers.
    always_ff @(posedge AXIS_ACLK) begin
        if (!AXIS_ARESETN) begin
            state_q    <= W_IDLE;
            wcnt_q     <= '0;
            bl_q       <= '0;
            drop_q     <= '0;
            stg_data_q <= '0;
            stg_vld_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            bl_q       <= bl_d;
            drop_q     <= drop_d;
            stg_data_q <= S_AXIS_TDATA;
            stg_vld_q  <= S_AXIS_TVALID;
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q <= cnt_q + {{PW{1'b0}}, wr_en} - {{PW{1'b0}}, rd_en};
        end
    end

    // FIFO storage; pointers wrap naturally because depth is a power of two.
    always_ff @(posedge AXIS_ACLK) begin
        if (AXIS_ARESETN && wr_en) mem[wr_ptr_q] <= wr_data;
    end

    assign M_AXIS_TVALID = (cnt_q != '0);
    assign {M_AXIS_TLAST, M_AXIS_TDATA} = M_AXIS_TVALID ? mem[rd_ptr_q] : '0;
    assign O_DROP_CNT = drop_q;
    assign O_BUSY     = (state_q == W_DATA);

endmodule

// File: tb/tb_trg_frame_tx.sv
// tb_trg_frame_tx: randomized scoreboard bench for trg_frame_tx.
// Works with or without TRG_TX_HEADER_EN defined.
`timescale 1ns/1ps
module tb_trg_frame_tx;

    localparam int DW    = 128;
    localparam int NL    = 8;
    localparam int FL    = 16;
    localparam int DEPTH = 64;
    localparam int OFS   = (10 * 4096) / 100;
    localparam logic [7:0] CHID = 8'h5C;
`ifdef TRG_TX_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    logic          clk = 1'b0;
    logic          rstn;
    logic [1:0]    exec;
    logic [11:0]   bl_in;
    logic          blv;
    logic [DW-1:0] sdata;
    logic          svalid;
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready;
    logic          tlast;
    logic [15:0]   drop;
    logic          busy;

    always #5 clk = ~clk;

    trg_frame_tx #(
        .THRESHOLD(10), .ADC_RESOLUTION_WIDTH(12), .S_AXIS_TDATA_WIDTH(DW),
        .FRAME_LEN(FL), .FIFO_DEPTH(DEPTH), .CH_ID(CHID)
    ) dut (
        .AXIS_ACLK(clk), .AXIS_ARESETN(rstn), .EXEC_STATE(exec),
        .I_BASELINE(bl_in), .I_BL_VALID(blv), .S_AXIS_TDATA(sdata),
        .S_AXIS_TVALID(svalid), .M_AXIS_TDATA(tdata), .M_AXIS_TVALID(tvalid),
        .M_AXIS_TREADY(tready), .M_AXIS_TLAST(tlast), .O_DROP_CNT(drop),
        .O_BUSY(busy)
    );

    int n_chk = 0;
    int n_fail = 0;
    logic [DW:0] exp_q[$];

    int            occ, m_rem, m_seq, m_drop, m_bl;
    bit            m_busy, p_vld;
    longint        m_ts;
    logic [DW-1:0] p_data;

    task automatic check(string nm, logic [DW:0] got, logic [DW:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic int s12(logic [11:0] r);
        int v;
        v = int'(r);
        if (v >= 2048) v -= 4096;
        return v;
    endfunction

    function automatic logic [DW-1:0] mkword(int base, int idx, int val);
        logic [DW-1:0] w;
        for (int i = 0; i < NL; i++) w[16*i +: 16] = 16'(base);
        if (idx >= 0) w[16*idx +: 16] = 16'(val);
        return w;
    endfunction

    function automatic logic [DW-1:0] noise(int base);
        logic [DW-1:0] w;
        for (int i = 0; i < NL; i++)
            w[16*i +: 16] = 16'(base + int'($urandom_range(0, 600)) - 300);
        return w;
    endfunction

    function automatic bit is_hit();
        bit h = 0;
        for (int i = 0; i < NL; i++)
            if (s12(sdata[16*i +: 12]) > s12(bl_in) + OFS) h = 1;
        return h && svalid && blv && (exec == 2'b11);
    endfunction

    // Reference model: what the DUT pushes into its FIFO on the coming edge.
    task automatic model_edge();
        bit rd, wr;
        logic [DW-1:0] w;
        int d;
        if (!rstn) begin
            exp_q.delete();
            occ = 0; m_busy = 0; m_seq = 0; m_drop = 0; m_ts = 0; p_vld = 0;
            return;
        end
        rd = (occ > 0) && tready;
        wr = 0;
        if (m_busy) begin
            if (p_vld) begin
                for (int i = 0; i < NL; i++) begin
                    d = s12(p_data[16*i +: 12]) - m_bl;
                    w[16*i +: 16] = 16'(d);
                end
                exp_q.push_back({m_rem == 1, w});
                m_rem--;
                wr = 1;
                if (m_rem == 0) m_busy = 0;
            end
        end else if (is_hit()) begin
            if (DEPTH - occ >= FL + HDR) begin
                if (HDR == 1) begin
                    w = '0;
                    w[127:120] = 8'hAA;
                    w[119:112] = CHID;
                    w[111:64]  = m_ts[47:0];
                    w[63:52]   = bl_in;
                    w[31:16]   = 16'(m_seq);
                    w[15:0]    = 16'(FL);
                    exp_q.push_back({1'b0, w});
                    wr = 1;
                end
                m_bl = s12(bl_in);
                m_busy = 1;
                m_rem = FL;
            end else if (m_drop < 65535) begin
                m_drop++;
            end
            m_seq = (m_seq + 1) % 65536;
        end
        occ = occ + int'(wr) - int'(rd);
        p_vld = svalid;
        p_data = sdata;
        m_ts++;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(string nm);
        int n = 0;
        svalid = 1;
        tready = 1;
        sdata = mkword(s12(bl_in), -1, 0);
        while ((exp_q.size() != 0 || m_busy) && n < 3000) begin
            tick();
            n++;
        end
        if (n >= 3000) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_timeout: queue %0d left, required 0", nm, exp_q.size());
        end
        repeat (3) tick();
        check({nm, "_empty"}, tvalid, 0);
        check({nm, "_drop"}, drop, m_drop);
        check({nm, "_busy"}, busy, 0);
    endtask

    logic        stall = 0;
    logic [DW:0] held;

    // Monitor: pops the scoreboard on every transfer, checks stall stability.
    always @(negedge clk) begin
        logic [DW:0] e;
        if (!rstn) begin
            stall = 0;
        end else begin
            if (stall) begin
                check("stall_tvalid", tvalid, 1);
                check("stall_data", {tlast, tdata}, held);
            end
            if (tvalid && tready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got %h required none", {tlast, tdata});
                end else begin
                    e = exp_q.pop_front();
                    check("beat", {tlast, tdata}, e);
                end
            end
            stall = tvalid && !tready;
            held = {tlast, tdata};
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 0; exec = 2'b11; bl_in = 12'd100; blv = 1;
        sdata = mkword(100, -1, 0); svalid = 1; tready = 1;
        repeat (3) tick();
        check("rst_tvalid", tvalid, 0);
        check("rst_tlast", tlast, 0);
        check("rst_tdata", tdata, 0);
        check("rst_drop", drop, 0);
        check("rst_busy", busy, 0);
        rstn = 1;

        repeat (1000) tick();
        check("quiet_tvalid", tvalid, 0);

        sdata = mkword(100, 3, 600); tick();
        sdata = mkword(100, -1, 0); repeat (30) tick();
        drain("single");

        sdata = mkword(100, 3, 600); tick();
        sdata = mkword(100, -1, 0);
        for (int i = 0; i < 60; i++) begin
            tready = ~tready;
            tick();
        end
        drain("toggle");

        tready = 0;
        for (int k = 0; k < 4; k++) begin
            sdata = mkword(100, 5, 700); tick();
            sdata = mkword(100, -1, 0); repeat (19) tick();
        end
        check("bp_drop", drop, HDR == 1 ? 1 : 0);
        check("bp_tvalid", tvalid, 1);
        drain("bp");

        blv = 0; sdata = mkword(100, 2, 2000); repeat (5) tick();
        blv = 1; exec = 2'b00; repeat (5) tick();
        exec = 2'b11; sdata = mkword(100, -1, 0); repeat (3) tick();
        check("gate_tvalid", tvalid, 0);

        sdata = mkword(100, 0, 509); repeat (3) tick();
        sdata = mkword(100, -1, 0); repeat (3) tick();
        check("thr_equal", tvalid, 0);
        sdata = mkword(100, 0, 510); tick();
        sdata = mkword(100, -1, 0); repeat (5) tick();
        exec = 2'b00; repeat (25) tick();
        exec = 2'b11;
        drain("exec_drop");

        sdata = mkword(100, 7, 900); tick();
        sdata = mkword(100, -1, 0); repeat (5) tick();
        rstn = 0; tick();
        check("mrst_tvalid", tvalid, 0);
        check("mrst_drop", drop, 0);
        check("mrst_busy", busy, 0);
        rstn = 1; repeat (4) tick();
        sdata = mkword(100, 1, 1500); tick();
        sdata = mkword(100, -1, 0);
        drain("post_rst");

        for (int c = 0; c < 4000; c++) begin
            int l;
            if ($urandom_range(0, 99) < 2) bl_in = 12'(int'($urandom_range(0, 1200)) - 600);
            exec = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
            blv = ($urandom_range(0, 29) != 0);
            svalid = ($urandom_range(0, 7) != 0);
            tready = (c < 2000) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 9) != 0);
            sdata = noise(s12(bl_in));
            l = int'($urandom_range(0, NL - 1));
            if ($urandom_range(0, 29) == 0)
                sdata[16*l +: 16] = 16'(s12(bl_in) + OFS + 1 + int'($urandom_range(0, 200)));
            else if ($urandom_range(0, 49) == 0)
                sdata[16*l +: 16] = 16'(s12(bl_in) + OFS);
            tick();
        end
        exec = 2'b11;
        blv = 1;
        drain("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
